// File: rtl/disp_msg_arbiter.sv
// Display-sharing arbiter: grants the 2-digit 7-seg display to one requester at a time.
// Define DISP_ARB_RR_EN for round-robin selection (fixed priority otherwise).
module disp_msg_arbiter #(
   parameter int NREQ     = 3,
   parameter int HOLD_CYC = 100_000_000,
   parameter int GAP_CYC  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      urgent,
   input  logic [14*NREQ-1:0]   msg,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [6:0]           disp_left,
   output logic [6:0]           disp_right,
   output logic                 disp_valid,
   output logic                 busy
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(HOLD_CYC + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYC - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [IDX_W-1:0] owner;

   logic             arb_hit;
   logic [IDX_W-1:0] arb_idx;
   logic [NREQ-1:0]  arb_onehot;
   logic             own_req;
   logic             own_urgent;
   logic             rival_req;
   logic             rival_urgent;
   logic             preempt;
   logic             hold_exit;
   logic             do_grant;
   logic [13:0]      owner_msg;
   logic [13:0]      winner_msg;

`ifdef DISP_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr;

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
      int c;
      c = int'(base) + k;
      if (c >= NREQ) c = c - NREQ;
      return IDX_W'(c);
   endfunction
`endif

   // Winner selection: scanning from the far end leaves the first hit in search order.
   always_comb begin
      arb_hit    = 1'b0;
      arb_idx    = '0;
      arb_onehot = '0;
`ifdef DISP_ARB_RR_EN
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[rr_index(rr_ptr, k)]) begin
            arb_hit = 1'b1;
            arb_idx = rr_index(rr_ptr, k);
         end
      end
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            arb_hit = 1'b1;
            arb_idx = IDX_W'(k);
         end
      end
`endif
      arb_onehot[arb_idx] = 1'b1;
   end

   // gnt is zero outside SHOW, so the owner-relative terms only matter while showing.
   always_comb begin
      own_req      = |(req & gnt);
      own_urgent   = |(req & urgent & gnt);
      rival_req    = |(req & ~gnt);
      rival_urgent = |(req & urgent & ~gnt);
      preempt      = rival_urgent & ~own_urgent;
      hold_exit    = (hold_cnt == '0) & (~own_req | rival_req);
      do_grant     = arb_hit & ((state == ST_IDLE) | ((state == ST_GAP) & (gap_cnt == '0)));
      owner_msg    = msg[14*int'(owner) +: 14];
      winner_msg   = msg[14*int'(arb_idx) +: 14];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         gnt        <= '0;
         done       <= '0;
         disp_left  <= '0;
         disp_right <= '0;
         disp_valid <= 1'b0;
         busy       <= 1'b0;
         hold_cnt   <= '0;
         gap_cnt    <= '0;
         owner      <= '0;
`ifdef DISP_ARB_RR_EN
         rr_ptr     <= '0;
`endif
      end else begin
         done <= '0;
         if (do_grant) begin
            state                   <= ST_SHOW;
            owner                   <= arb_idx;
            gnt                     <= arb_onehot;
            {disp_left, disp_right} <= winner_msg;
            disp_valid              <= 1'b1;
            busy                    <= 1'b1;
            hold_cnt                <= HOLD_LOAD;
            gap_cnt                 <= '0;
`ifdef DISP_ARB_RR_EN
            rr_ptr <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
         end else begin
            case (state)
               ST_SHOW: begin
                  if (preempt | hold_exit) begin
                     state      <= ST_GAP;
                     done       <= gnt;
                     gnt        <= '0;
                     disp_left  <= '0;
                     disp_right <= '0;
                     disp_valid <= 1'b0;
                     gap_cnt    <= GAP_LOAD;
                  end else begin
                     // Dropping the request freezes whatever was last latched.
                     if (own_req) {disp_left, disp_right} <= owner_msg;
                     if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               ST_GAP: begin
                  if (gap_cnt != '0) begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               ST_IDLE: ;
               default: begin
                  state      <= ST_IDLE;
                  gnt        <= '0;
                  disp_left  <= '0;
                  disp_right <= '0;
                  disp_valid <= 1'b0;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_disp_msg_arbiter.sv
// Scoreboard bench for disp_msg_arbiter: a requester-level reference model predicts every
// cycle's outputs into a queue, and an independent monitor pops and compares them.
module tb_disp_msg_arbiter;

   localparam int NREQ     = 3;
   localparam int HOLD_CYC = 4;
   localparam int GAP_CYC  = 2;

   localparam logic [6:0] S_0 = 7'b0111111;
   localparam logic [6:0] S_1 = 7'b0000110;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      urgent;
   logic [14*NREQ-1:0]   msg;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic [6:0]           disp_left;
   logic [6:0]           disp_right;
   logic                 disp_valid;
   logic                 busy;

   always #5 clk = ~clk;

   disp_msg_arbiter #(
      .NREQ     (NREQ),
      .HOLD_CYC (HOLD_CYC),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .urgent     (urgent),
      .msg        (msg),
      .gnt        (gnt),
      .done       (done),
      .disp_left  (disp_left),
      .disp_right (disp_right),
      .disp_valid (disp_valid),
      .busy       (busy)
   );

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic [NREQ-1:0] done;
      logic [13:0]     disp;
      logic            valid;
      logic            busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: who owns the screen, how long it has been shown, gap cycles left.
   int          m_owner;
   int          m_shown;
   int          m_gap;
   int          m_ptr;
   logic [13:0] m_msg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_shown = 0;
      m_gap   = 0;
      m_ptr   = 0;
      m_msg   = '0;
   endtask

   function automatic logic [13:0] msg_of(input logic [14*NREQ-1:0] m, input int i);
      return m[14*i +: 14];
   endfunction

   task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] u,
                             input logic [14*NREQ-1:0] m);
      exp_t            e;
      logic [NREQ-1:0] done_v;
      bit              own, own_urg, rival, rival_urg;
      int              i;
      done_v = '0;
      if (m_owner >= 0) begin
         own       = r[m_owner];
         own_urg   = r[m_owner] & u[m_owner];
         rival     = 1'b0;
         rival_urg = 1'b0;
         for (int j = 0; j < NREQ; j++) begin
            if (j != m_owner) begin
               if (r[j]) rival = 1'b1;
               if (r[j] && u[j]) rival_urg = 1'b1;
            end
         end
         if ((rival_urg && !own_urg) || (m_shown >= HOLD_CYC && (!own || rival))) begin
            done_v[m_owner] = 1'b1;
            m_owner = -1;
            m_gap   = GAP_CYC;
         end else begin
            if (own) m_msg = msg_of(m, m_owner);
            m_shown++;
         end
      end else if (m_gap > 1) begin
         m_gap--;
      end else begin
         m_gap = 0;
         for (int k = 0; k < NREQ; k++) begin
`ifdef DISP_ARB_RR_EN
            i = (m_ptr + k) % NREQ;
`else
            i = k;
`endif
            if (r[i]) begin
               m_owner = i;
               m_msg   = msg_of(m, i);
               m_shown = 1;
               m_ptr   = (i + 1) % NREQ;
               break;
            end
         end
      end
      e.gnt = '0;
      if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
      e.done  = done_v;
      e.disp  = (m_owner >= 0) ? m_msg : 14'h0;
      e.valid = (m_owner >= 0);
      e.busy  = (m_owner >= 0) || (m_gap > 0);
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs (called at a falling edge) and queue the predicted response.
   task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] u,
                       input logic [14*NREQ-1:0] m);
      req    = r;
      urgent = u;
      msg    = m;
      model_edge(r, u, m);
      @(negedge clk);
   endtask

   task automatic step_n(input logic [NREQ-1:0] r, input logic [NREQ-1:0] u,
                         input logic [14*NREQ-1:0] m, input int n);
      for (int c = 0; c < n; c++) step(r, u, m);
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, "_gnt"},   32'(gnt),        32'(0));
      chk({tag, "_done"},  32'(done),       32'(0));
      chk({tag, "_left"},  32'(disp_left),  32'(0));
      chk({tag, "_right"}, 32'(disp_right), 32'(0));
      chk({tag, "_valid"}, 32'(disp_valid), 32'(0));
      chk({tag, "_busy"},  32'(busy),       32'(0));
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",        32'(gnt),        32'(e.gnt));
            chk("done",       32'(done),       32'(e.done));
            chk("disp_left",  32'(disp_left),  32'(e.disp[13:7]));
            chk("disp_right", 32'(disp_right), 32'(e.disp[6:0]));
            chk("disp_valid", 32'(disp_valid), 32'(e.valid));
            chk("busy",       32'(busy),       32'(e.busy));
         end
      end
   end

   // Stimulus
   initial begin
      logic [NREQ-1:0]    r, u;
      logic [14*NREQ-1:0] m, m_dir;
      logic [63:0]        rnd;

      rst    = 1'b1;
      req    = '0;
      urgent = '0;
      msg    = '0;
      model_reset();
      #2;
      chk_blank("reset");
      @(negedge clk);
      rst = 1'b0;

      m_dir = {7'h5b, 7'h4f, 7'h66, 7'h6d, S_1, S_0};

      step_n(3'b001, 3'b000, m_dir, 6);
      step_n(3'b000, 3'b000, m_dir, 8);
      step_n(3'b001, 3'b000, m_dir, 2);
      step_n(3'b011, 3'b000, m_dir, 6);
      step_n(3'b010, 3'b000, m_dir, 5);
      step_n(3'b011, 3'b001, m_dir, 8);

      step_n(3'b000, 3'b000, m_dir, 8);
      step(3'b001, 3'b000, m_dir);
      step_n(3'b000, 3'b000, {m_dir[41:14], 14'h1abc}, 10);

      step_n(3'b111, 3'b000, m_dir, 30);

      step_n(3'b001, 3'b000, m_dir, 3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_blank("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step_n(3'b001, 3'b000, m_dir, 8);

      r = '0;
      m = m_dir;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         u = '0;
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 11) == 0) u[i] = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) begin
            rnd = {$urandom(), $urandom()};
            m   = rnd[14*NREQ-1:0];
         end
         step(r, u, m);
      end

      step_n(3'b000, 3'b000, m_dir, 10);
      @(posedge clk);
      #2;
      chk("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
